// File: rtl/mult_share_sched.sv
// Purpose: round-robin time-sharing of one external pipelined multiplier
//          (normmult) among 4 channels. Each channel has its own coefficient register.
// Latency: MULT_LAT+1 clk edges from the transfer edge to res_valid.
// Backpressure: ack is combinational. It is withheld while en=0 or arst=1.
//               Ops already in flight always drain to a result.
// Ports: clk/arst clock and async reset; en/req/din/ack request side;
//        cfg_* coefficient writes; m_* shared multiplier; res_* result; busy.
module mult_share_sched #(
    parameter int MULT_LAT = 2
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        en,
    input  logic [3:0]  req,
    input  logic [63:0] din,
    output logic [3:0]  ack,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_data,
    output logic [15:0] m_din,
    output logic [15:0] m_coef,
    input  logic [15:0] m_dout,
    output logic        res_valid,
    output logic [1:0]  res_ch,
    output logic [15:0] res_data,
    output logic        busy
);
    localparam int NCH = 4;

    typedef struct packed {
        logic       vld;
        logic [1:0] ch;
    } tag_t;

    logic [1:0]  ptr_q, ptr_d;
    logic [15:0] coef_q [NCH];
    logic [15:0] m_din_q, m_coef_q;
    tag_t        tag0_q;              // tag aligned with the m_din/m_coef registers
    tag_t        pipe_q [MULT_LAT];   // follows the multiplier's internal stages
    logic        res_valid_q;
    logic [1:0]  res_ch_q;
    logic [15:0] res_data_q;

    logic        gnt;
    logic [1:0]  gnt_ch;
    logic [1:0]  cand;

    // Round-robin search starting at ptr_q, which holds (last granted + 1).
    always_comb begin
        gnt    = 1'b0;
        gnt_ch = ptr_q;
        cand   = ptr_q;
        if (!arst && en) begin
            for (int i = 0; i < NCH; i++) begin
                cand = ptr_q + i[1:0];
                if (!gnt && req[cand]) begin
                    gnt    = 1'b1;
                    gnt_ch = cand;
                end
            end
        end
    end

    assign ack   = gnt ? (4'b0001 << gnt_ch) : 4'b0000;
    assign ptr_d = gnt ? gnt_ch + 2'd1 : ptr_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ptr_q    <= 2'd0;
            m_din_q  <= 16'h0000;
            m_coef_q <= 16'h0000;
            tag0_q   <= '0;
            for (int i = 0; i < NCH; i++) coef_q[i] <= 16'h8000;
        end else begin
            ptr_q  <= ptr_d;
            tag0_q <= '{vld: gnt, ch: gnt_ch};
            if (gnt) begin
                m_din_q  <= din[{gnt_ch, 4'b0000} +: 16];
                // The table read uses the pre-edge value, so a simultaneous
                // write to the same channel takes effect on the next op.
                m_coef_q <= coef_q[gnt_ch];
            end
            if (cfg_we) coef_q[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < MULT_LAT; i++) pipe_q[i] <= '0;
            res_valid_q <= 1'b0;
            res_ch_q    <= 2'd0;
            res_data_q  <= 16'h0000;
        end else begin
            pipe_q[0] <= tag0_q;
            for (int i = 1; i < MULT_LAT; i++) pipe_q[i] <= pipe_q[i-1];
            res_valid_q <= pipe_q[MULT_LAT-1].vld;
            // Results with no valid tag are ignored, so only update on valid.
            if (pipe_q[MULT_LAT-1].vld) begin
                res_ch_q   <= pipe_q[MULT_LAT-1].ch;
                res_data_q <= m_dout;
            end
        end
    end

    always_comb begin
        busy = tag0_q.vld | res_valid_q;
        for (int i = 0; i < MULT_LAT; i++) busy = busy | pipe_q[i].vld;
    end

    assign m_din     = m_din_q;
    assign m_coef    = m_coef_q;
    assign res_valid = res_valid_q;
    assign res_ch    = res_ch_q;
    assign res_data  = res_data_q;
endmodule

// File: doc/mult_share_sched.md
MULT_SHARE_SCHED -- requirements
Module: mult_share_sched

Interface
REQ-001 Parameter: MULT_LAT, default 2, latency in clk edges from m_din/m_coef update to matching m_dout.
REQ-002 Parameter: NCH, fixed 4, number of requesting channels.
REQ-003 Ports, in order:
- clk  in  1  sole clock, rising edge.
- arst  in  1  reset, asynchronous, active-high.
- en  in  1  grant enable.
- req  in  4  per-channel request.
- din  in  64  channel data, 16 bits per channel; channel k in bits [16k+15:16k].
- ack  out  4  one-hot grant, combinational.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  2  coefficient channel index.
- cfg_data  in  16  coefficient value.
- m_din  out  16  to shared normmult din.
- m_coef  out  16  to shared normmult coef.
- m_dout  in  16  from shared normmult dout.
- res_valid  out  1  result strobe.
- res_ch  out  2  result channel.
- res_data  out  16  result value.
- busy  out  1  any operation in flight.

Function
REQ-004 The block SHALL time-share one external normmult among 4 channels, one operation per clk at most.
REQ-005 ack SHALL be combinational: at most one bit high, only when en=1 and that channel's req=1.
- Transfer occurs at the rising edge where req[k]&ack[k]=1.
- req may stay high for back-to-back transfers.
REQ-006 Arbitration SHALL be round-robin.
- Search starts at channel (last_granted+1) mod 4.
- After reset the pointer makes ch0 highest priority.
- The pointer updates only on a transfer.
REQ-007 On transfer of channel k at edge E0, the block SHALL register:
- m_din <= din[k], m_coef <= coef[k];
- a tag {valid=1, ch=k} into a MULT_LAT-deep tag shift register.
REQ-008 With no transfer, m_din and m_coef SHALL hold their values, and a tag {valid=0} SHALL be shifted in.
REQ-009 At edge E0+MULT_LAT+1 the block SHALL register res_data <= m_dout, res_ch <= k and res_valid <= 1.
- res_valid is high for exactly one cycle per transfer.
- Total latency from ack to res_valid is MULT_LAT+1 cycles.
REQ-010 Results SHALL emerge in grant order; none is dropped or duplicated under continuous traffic.
REQ-011 Coefficient table SHALL be 4x16 registers, written at a clk edge when cfg_we=1: coef[cfg_addr] <= cfg_data.
REQ-012 Simultaneous cfg write and transfer of the same channel SHALL use the old coefficient (read-before-write).
REQ-013 When en=0, no new grants SHALL be issued; in-flight tags SHALL still drain and produce results.
REQ-014 busy SHALL be high whenever any tag-pipe valid bit is 1 or res_valid=1.

Reset
REQ-015 On arst=1, independent of clk, the block SHALL force:
- m_din=0, m_coef=0;
- all tags invalid;
- res_valid=0, res_ch=0, res_data=0;
- priority pointer to ch0;
- every coef entry to 16'h8000.
REQ-016 Reset asserted mid-operation SHALL discard all in-flight operations; no res_valid appears for them after release.
REQ-017 While arst=1, ack SHALL be 0.

Verification
REQ-018 The bench SHALL model normmult as a MULT_LAT-stage delay of (m_din, m_coef) feeding a reference product. It SHALL cover:
- Single channel: req=0001, din0=16'h0100, after reset -> ack=0001 for one cycle; m_din=16'h0100, m_coef=16'h8000; res_valid with res_ch=0 exactly 3 cycles later (MULT_LAT=2).
- All four channels requesting continuously for 8 cycles -> ack sequence 0,1,2,3,0,1,2,3; 8 results in the same channel order; res_valid high 8 consecutive cycles.
- cfg_we with cfg_addr=2, cfg_data=16'h4000 on the same edge as a ch2 transfer -> that op uses m_coef=16'h8000; the next ch2 op uses 16'h4000.
- en dropped with 2 ops in flight -> ack=0 immediately; both results delivered; busy falls after the last res_valid.
- arst pulsed one cycle after a transfer -> no res_valid for that op; m_din=0; next grant goes to ch0 with req=1111.
- req=1010 after a ch1 grant -> next grant ch3, then ch1; no grant to unrequested channels.
